// File: rtl/mult_sa_nb.sv
// Sequential unsigned n x n shift-and-add multiplier built around one n-bit
// ripple-carry adder; one product every n+2 clocks.

module rca #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         co
);
    logic [n:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[n];
endmodule

module mult_sa_nb #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic [2*n-1:0] prod,
    output logic           busy,
    output logic           done
);
    localparam int cw = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [n-1:0]  mcand;
    logic [n-1:0]  acc;
    logic [n-1:0]  mq;
    logic [cw-1:0] cnt;

    logic [n-1:0]  add_b;
    logic [n-1:0]  sum;
    logic          co;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b = mq[0] ? mcand : '0;

    rca #(.n(n)) u_rca (
        .a   (acc),
        .b   (add_b),
        .cin (1'b0),
        .sum (sum),
        .co  (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prod  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Carry out lands in acc[n-1], so no product bit is ever lost.
                    acc <= {co, sum[n-1:1]};
                    mq  <= {sum[0], mq[n-1:1]};
                    cnt <= cnt + cw'(1);
                    if (cnt == cw'(n - 1)) begin
                        prod  <= {co, sum, mq[n-1:1]};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_sa_nb.sv
// Bench for mult_sa_nb: n=8, n=4 and n=16 instances checked every cycle
// against a timing-level product model, plus directed literal expectations.

module tb_mult_sa_nb;
    logic        clk;
    logic        rst;
    logic        st [3];
    logic [15:0] av [3];
    logic [15:0] bv [3];

    logic [15:0] p8;
    logic [7:0]  p4;
    logic [31:0] p16;
    logic        bz8, bz4, bz16, dn8, dn4, dn16;
    logic [2:0]  bzv, dnv;

    int pass_cnt, total_cnt;
    int cyc;
    int dcount [3];
    int bcount [3];
    logic armed;

    // Model: mcnt counts clocks since the accepting edge, 0 when idle.
    int          mcnt  [3];
    logic [31:0] mpend [3];
    logic [31:0] mprod [3];

    assign bzv = {bz16, bz4, bz8};
    assign dnv = {dn16, dn4, dn8};

    mult_sa_nb #(.n(8)) u8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
        .prod(p8), .busy(bz8), .done(dn8));
    mult_sa_nb #(.n(4)) u4 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
        .prod(p4), .busy(bz4), .done(dn4));
    mult_sa_nb #(.n(16)) u16 (
        .clk(clk), .rst(rst), .start(st[2]), .a(av[2]), .b(bv[2]),
        .prod(p16), .busy(bz16), .done(dn16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nn(int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 16;
    endfunction

    function automatic logic [31:0] getp(int k);
        return (k == 0) ? {16'h0, p8} : (k == 1) ? {24'h0, p4} : p16;
    endfunction

    function automatic logic [31:0] opmask(int k, logic [15:0] v);
        logic [31:0] m;
        m = (32'h1 << nn(k)) - 32'h1;
        return {16'h0, v} & m;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mcnt[k]  <= 0;
                mprod[k] <= '0;
            end else if (mcnt[k] == 0) begin
                if (st[k]) begin
                    mcnt[k]  <= 1;
                    mpend[k] <= opmask(k, av[k]) * opmask(k, bv[k]);
                end
            end else if (mcnt[k] == nn(k)) begin
                mprod[k] <= mpend[k];
                mcnt[k]  <= mcnt[k] + 1;
            end else if (mcnt[k] == nn(k) + 1) begin
                mcnt[k] <= 0;
            end else begin
                mcnt[k] <= mcnt[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (bzv[k] !== 1'b0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", {31'h0, bzv[k]}, 32'h0);
    endtask

    // One-cycle start pulse; returns latency in edges from accept to done.
    task automatic op(input int k, input logic [15:0] x, input logic [15:0] y,
                      output int lat);
        wait_idle(k);
        av[k] = x;
        bv[k] = y;
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        lat = 0;
        while (dnv[k] !== 1'b1 && lat < 4 * nn(k)) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, d0, b0, t1, t2;
        logic [15:0] x, y;
        pass_cnt = 0;
        total_cnt = 0;
        cyc = 0;
        armed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            av[k] = '0;
            bv[k] = '0;
            dcount[k] = 0;
            bcount[k] = 0;
            mcnt[k] = 0;
            mpend[k] = '0;
            mprod[k] = '0;
        end

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (armed) begin
                    for (int k = 0; k < 3; k++) begin
                        chk($sformatf("prod_n%0d", nn(k)), getp(k), mprod[k]);
                        chk($sformatf("busy_n%0d", nn(k)), {31'h0, bzv[k]}, {31'h0, mcnt[k] != 0});
                        chk($sformatf("done_n%0d", nn(k)), {31'h0, dnv[k]}, {31'h0, mcnt[k] == nn(k) + 1});
                        if (dnv[k] === 1'b1) dcount[k]++;
                        if (bzv[k] === 1'b1) bcount[k]++;
                    end
                end
            end
        join_none

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        chk("reset_prod", {16'h0, p8}, 32'h0);
        chk("reset_busy", {31'h0, bz8}, 32'h0);
        chk("reset_done", {31'h0, dn8}, 32'h0);
        repeat (20) @(negedge clk);
        chk("idle_prod", {16'h0, p8}, 32'h0);
        chk("idle_dcount", dcount[0], 0);

        // 13 * 11
        b0 = bcount[0];
        d0 = dcount[0];
        op(0, 16'd13, 16'd11, lat);
        chk("lat_13x11", lat, 8);
        chk("prod_13x11", {16'h0, p8}, 32'h008F);
        wait_idle(0);
        chk("busy_cycles_13x11", bcount[0] - b0, 9);
        chk("dpulse_13x11", dcount[0] - d0, 1);

        op(0, 16'd255, 16'd255, lat);
        chk("prod_255x255", {16'h0, p8}, 32'hFE01);
        op(0, 16'd0, 16'd200, lat);
        chk("prod_0x200", {16'h0, p8}, 32'h0000);
        op(0, 16'd200, 16'd1, lat);
        chk("prod_200x1", {16'h0, p8}, 32'h00C8);

        // start and operand changes during CALC are ignored
        wait_idle(0);
        d0 = dcount[0];
        av[0] = 16'd7; bv[0] = 16'd9; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        av[0] = 16'd3; bv[0] = 16'd3; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        lat = 0;
        while (dn8 !== 1'b1 && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        chk("prod_7x9_midstart", {16'h0, p8}, 32'h003F);
        repeat (15) @(negedge clk);
        chk("dpulse_midstart", dcount[0] - d0, 1);

        // held start: one product every 10 cycles
        wait_idle(0);
        av[0] = 16'd5; bv[0] = 16'd6; st[0] = 1'b1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dn8 === 1'b1) begin
                if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
            end
        end
        st[0] = 1'b0;
        chk("held_start_period", t2 - t1, 10);
        chk("prod_5x6", {16'h0, p8}, 32'h001E);

        // reset mid-operation
        wait_idle(0);
        d0 = dcount[0];
        av[0] = 16'd100; bv[0] = 16'd100; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'h0, bz8}, 32'h0);
        chk("abort_prod", {16'h0, p8}, 32'h0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", dcount[0] - d0, 0);
        op(0, 16'd100, 16'd100, lat);
        chk("prod_100x100", {16'h0, p8}, 32'h2710);

        // n=4 exhaustive
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op(1, 16'(i), 16'(j), lat);
                chk("lat_n4", lat, 4);
                chk("prod_n4", {24'h0, p4}, 32'(i * j));
            end
        end

        // n=16 corner plus random pairs
        op(2, 16'hFFFF, 16'hFFFF, lat);
        chk("prod_ffff_sq", p16, 32'hFFFE0001);
        chk("lat_n16_corner", lat, 16);
        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            op(2, x, y, lat);
            chk("lat_n16", lat, 16);
            chk("prod_n16", p16, {16'h0, x} * {16'h0, y});
        end
        wait_idle(2);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
